// File: rtl/sd_arb_pkg.sv
// Shared types and helpers for the HPS block-channel arbiter.
package sd_arb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, XFER, HOLD} arb_state_t;

  localparam logic [23:0] TIMEOUT_DEF = 24'd5000000;
  localparam int PICK_MAX = 32;

  // Returns {valid, index}: first set bit of req scanning upward from last+1, modulo n.
  function automatic logic [5:0] rr_pick(input logic [31:0] req, input logic [4:0] last,
                                         input int n);
    logic       found;
    logic [4:0] idx;
    int         cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= PICK_MAX; k++) begin
      cand = (int'(last) + k) % n;
      if (k <= n && !found && req[cand[4:0]]) begin
        found = 1'b1;
        idx   = cand[4:0];
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/sd_block_arbiter_pick.sv
// Combinational round-robin picker over NREQ request lines.
module rr_pick_nreq
  import sd_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int OW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   last,
  output logic            valid,
  output logic [OW-1:0]   winner
);

  logic [5:0] pick;

  always_comb begin
    pick = rr_pick(32'(req), 5'(last), NREQ);
  end

  assign valid  = pick[5];
  assign winner = OW'(pick[4:0]);

endmodule

// File: rtl/sd_block_arbiter.sv
// Shares the single hps_io virtual-disk block channel between NREQ storage clients.
//
// state | meaning
// IDLE  | channel free, grant when sd_ack low and a request is pending
// REQ   | strobe to hps_io asserted, waiting for sd_ack (with timeout)
// XFER  | transfer running, waiting for sd_ack to fall
// HOLD  | one-cycle gap so the finished requester can drop its level
module sd_block_arbiter
  import sd_arb_pkg::*;
#(
  parameter int          NREQ    = 4,
  parameter logic [23:0] TIMEOUT = TIMEOUT_DEF,
  parameter int          OW      = $clog2(NREQ)
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_rd,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [NREQ*32-1:0]   req_lba,
  output logic [NREQ-1:0]      req_done,
  output logic [NREQ-1:0]      req_err,
  output logic [NREQ-1:0]      req_act,
  output logic [NREQ-1:0]      req_buff_wr,
  output logic [31:0]          sd_lba,
  output logic [NREQ-1:0]      sd_rd,
  output logic [NREQ-1:0]      sd_wr,
  input  logic                 sd_ack,
  input  logic                 sd_buff_wr,
  output logic                 busy,
  output logic [OW-1:0]        owner
);

  arb_state_t      state, state_nxt;
  logic [OW-1:0]   owner_nxt;
  logic [31:0]     lba_nxt;
  logic [NREQ-1:0] act_nxt, rd_nxt, wr_nxt, done_nxt, err_nxt;
  logic [NREQ-1:0] grant_oh, owner_oh, req_any;
  logic [23:0]     cnt, cnt_nxt;
  logic            pick_valid;
  logic [OW-1:0]   winner;
  logic [31:0]     lba_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_lba
    assign lba_arr[i] = req_lba[32*i +: 32];
  end

  assign req_any = req_rd | req_wr;

  rr_pick_nreq #(.NREQ(NREQ), .OW(OW)) u_pick (
    .req    (req_any),
    .last   (owner),
    .valid  (pick_valid),
    .winner (winner)
  );

  assign grant_oh    = NREQ'(1) << winner;
  assign owner_oh    = NREQ'(1) << owner;
  assign busy        = (state != IDLE);
  assign req_buff_wr = {NREQ{sd_buff_wr}} & req_act;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    lba_nxt   = sd_lba;
    act_nxt   = req_act;
    rd_nxt    = sd_rd;
    wr_nxt    = sd_wr;
    done_nxt  = '0;
    err_nxt   = '0;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        // A high sd_ack here belongs to a transfer nobody owns any more.
        if (!sd_ack && pick_valid) begin
          state_nxt = REQ;
          owner_nxt = winner;
          lba_nxt   = lba_arr[winner];
          act_nxt   = grant_oh;
          if (req_rd[winner]) rd_nxt = grant_oh;
          else                wr_nxt = grant_oh;
          cnt_nxt   = '0;
        end
      end
      REQ: begin
        if (sd_ack) begin
          rd_nxt    = '0;
          wr_nxt    = '0;
          state_nxt = XFER;
        end else if (cnt == TIMEOUT - 24'd1) begin
          rd_nxt    = '0;
          wr_nxt    = '0;
          act_nxt   = '0;
          err_nxt   = owner_oh;
          state_nxt = HOLD;
        end else if (cnt != '1) begin
          cnt_nxt = cnt + 24'd1;
        end
      end
      XFER: begin
        if (!sd_ack) begin
          act_nxt   = '0;
          done_nxt  = owner_oh;
          state_nxt = HOLD;
        end
      end
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      sd_lba   <= '0;
      req_act  <= '0;
      sd_rd    <= '0;
      sd_wr    <= '0;
      req_done <= '0;
      req_err  <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      sd_lba   <= lba_nxt;
      req_act  <= act_nxt;
      sd_rd    <= rd_nxt;
      sd_wr    <= wr_nxt;
      req_done <= done_nxt;
      req_err  <= err_nxt;
      cnt      <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Scoreboard bench for sd_block_arbiter: model predicts grant order and completions.
module tb_sd_block_arbiter;

  localparam int NREQ = 4;
  localparam int TMO  = 100;

  logic           clk_sys = 1'b0;
  logic           reset;
  logic [3:0]     req_rd, req_wr;
  logic [127:0]   req_lba;
  logic [3:0]     req_done, req_err, req_act, req_buff_wr;
  logic [31:0]    sd_lba;
  logic [3:0]     sd_rd, sd_wr;
  logic           sd_ack, sd_buff_wr;
  logic           busy;
  logic [1:0]     owner;

  typedef struct {
    bit          is_grant;
    int          mode;      // grant cycle: 0 absolute, 1 after previous completion, 2 after ack fall
    int          exp_cyc;
    int          own;
    logic [3:0]  rd, wr;
    logic [31:0] lba;
    logic [3:0]  done, err;
    int          buff;
  } ev_t;

  typedef struct {
    bit ack;
    int dly, len, pulses;
  } plan_t;

  ev_t   exp_q[$];
  plan_t plan_q[$];
  int    cyc = 0, pass_cnt = 0, chk_cnt = 0;
  int    ack_rise_cyc = 0, ack_fall_cyc = 0;
  int    buff_total = 0, buff_at_grant = 0;
  int    rem[4];
  int    m_last = 0;

  sd_block_arbiter #(.NREQ(NREQ), .TIMEOUT(24'(TMO))) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .req_rd      (req_rd),
    .req_wr      (req_wr),
    .req_lba     (req_lba),
    .req_done    (req_done),
    .req_err     (req_err),
    .req_act     (req_act),
    .req_buff_wr (req_buff_wr),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .sd_buff_wr  (sd_buff_wr),
    .busy        (busy),
    .owner       (owner)
  );

  always #5 clk_sys = ~clk_sys;

  initial forever begin
    @(posedge clk_sys);
    cyc++;
  end

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // hps_io model: answers each strobe according to the next plan
  task automatic serve(input plan_t p);
    if (p.ack) begin
      repeat (p.dly) tick();
      sd_ack = 1'b1;
      ack_rise_cyc = cyc;
      for (int k = 0; k < p.len; k++) begin
        sd_buff_wr = ((k % 2) == 1) && ((k / 2) < p.pulses);
        tick();
      end
      sd_ack = 1'b0;
      sd_buff_wr = 1'b0;
      ack_fall_cyc = cyc;
    end else begin
      for (int k = 0; k < TMO + 20 && (sd_rd | sd_wr) != 0; k++) tick();
      chk("host_strobe_dropped", sd_rd | sd_wr, 0);
    end
  endtask

  initial begin
    plan_t p;
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    forever begin
      tick();
      if ((sd_rd | sd_wr) != 0) begin
        if (plan_q.size() == 0) chk("host_plan_available", sd_rd | sd_wr, 0);
        else begin
          p = plan_q.pop_front();
          serve(p);
        end
      end
    end
  end

  // Monitor: pops expectations on grant and on completion
  initial begin
    logic [3:0] prev_act, prev_stb;
    int grant_cyc, last_compl, stb_fall, busy_chk_at, expc, others;
    int bcnt[4];
    ev_t e;
    prev_act = '0; prev_stb = '0;
    grant_cyc = 0; last_compl = 0; stb_fall = 0; busy_chk_at = -1;
    for (int i = 0; i < 4; i++) bcnt[i] = 0;
    forever begin
      @(negedge clk_sys);
      if (prev_stb != 0 && (sd_rd | sd_wr) == 0) stb_fall = cyc;
      if (cyc == busy_chk_at) begin
        chk("busy_after_end", busy, 0);
        chk("act_after_end", req_act, 0);
      end
      if (prev_act == 0 && req_act != 0) begin
        grant_cyc = cyc;
        buff_at_grant = buff_total;
        for (int i = 0; i < 4; i++) bcnt[i] = 0;
        if (exp_q.size() == 0 || !exp_q[0].is_grant) chk("grant_expected", req_act, 0);
        else begin
          e = exp_q.pop_front();
          expc = (e.mode == 0) ? e.exp_cyc : (e.mode == 1) ? last_compl + 2 : ack_fall_cyc + 1;
          chk("grant_owner", owner, e.own);
          chk("grant_act", req_act, 1 << e.own);
          chk("grant_sd_rd", sd_rd, e.rd);
          chk("grant_sd_wr", sd_wr, e.wr);
          chk("grant_sd_lba", sd_lba, e.lba);
          chk("grant_cycle", cyc, expc);
        end
      end
      for (int i = 0; i < 4; i++)
        if (req_buff_wr[i]) begin
          bcnt[i]++;
          buff_total++;
        end
      if ((req_done | req_err) != 0) begin
        if (exp_q.size() == 0 || exp_q[0].is_grant) chk("compl_expected", req_done | req_err, 0);
        else begin
          e = exp_q.pop_front();
          chk("compl_done", req_done, e.done);
          chk("compl_err", req_err, e.err);
          if (e.err != 0) begin
            chk("err_cycle", cyc, grant_cyc + TMO);
            chk("err_strobe_fall", stb_fall, grant_cyc + TMO);
          end else begin
            chk("done_cycle", cyc, ack_fall_cyc + 1);
            chk("strobe_fall", stb_fall, ack_rise_cyc + 1);
          end
          others = 0;
          for (int i = 0; i < 4; i++) if (i != e.own) others += bcnt[i];
          chk("buff_owner_pulses", bcnt[e.own], e.buff);
          chk("buff_other_pulses", others, 0);
        end
        last_compl = cyc;
        busy_chk_at = cyc + 1;
      end
      prev_act = req_act;
      prev_stb = sd_rd | sd_wr;
    end
  end

  task automatic wait_round();
    for (int k = 0; k < 20000 && (exp_q.size() != 0 || busy); k++) begin
      tick();
      for (int i = 0; i < 4; i++)
        if (req_done[i] | req_err[i]) begin
          rem[i]--;
          if (rem[i] <= 0) begin
            req_rd[i] = 1'b0;
            req_wr[i] = 1'b0;
          end
        end
    end
    chk("round_drained", exp_q.size(), 0);
    if (exp_q.size() != 0) begin
      exp_q.delete();
      plan_q.delete();
      req_rd = '0;
      req_wr = '0;
    end
    repeat (3) tick();
  endtask

  // Requests are raised together on an idle channel; the model serves them
  // round-robin from the last owner, each requester `twice`-flagged served twice.
  task automatic run_round(input logic [3:0] rdm, input logic [3:0] wrm, input logic [127:0] lbas,
                           input logic [3:0] twice, input int dly, input int len, input int pulses,
                           input bit ack);
    int    c[4];
    int    sel, j;
    bit    first;
    ev_t   g, f;
    plan_t p;
    tick();
    for (int i = 0; i < 4; i++) begin
      c[i] = (rdm[i] | wrm[i]) ? 1 + int'(twice[i]) : 0;
      rem[i] = c[i];
    end
    first = 1'b1;
    for (int n = 0; n < 8; n++) begin
      sel = -1;
      for (int k = 1; k <= 4; k++) begin
        j = (m_last + k) % 4;
        if (sel < 0 && c[j] > 0) sel = j;
      end
      if (sel < 0) break;
      c[sel]--;
      m_last = sel;
      if (dly < 0) begin
        p.ack    = ($urandom_range(0, 5) != 0);
        p.dly    = $urandom_range(1, 8);
        p.len    = $urandom_range(2, 30);
        p.pulses = $urandom_range(0, p.len / 2);
      end else begin
        p.ack = ack; p.dly = dly; p.len = len; p.pulses = pulses;
      end
      g = '{default: 0};
      g.is_grant = 1'b1;
      g.mode     = first ? 0 : 1;
      g.exp_cyc  = cyc + 1;
      g.own      = sel;
      g.rd       = rdm[sel] ? 4'(1 << sel) : 4'b0;
      g.wr       = rdm[sel] ? 4'b0 : 4'(1 << sel);
      g.lba      = lbas[32*sel +: 32];
      f = '{default: 0};
      f.own  = sel;
      f.done = p.ack ? 4'(1 << sel) : 4'b0;
      f.err  = p.ack ? 4'b0 : 4'(1 << sel);
      f.buff = p.ack ? p.pulses : 0;
      exp_q.push_back(g);
      exp_q.push_back(f);
      plan_q.push_back(p);
      first = 1'b0;
    end
    req_lba = lbas;
    req_rd  = rdm;
    req_wr  = wrm;
    wait_round();
  endtask

  initial begin
    ev_t         g, f;
    plan_t       p;
    int          buff_snap;
    logic [3:0]  mask, rdm, wrm, twice;
    int          r;
    reset = 1'b1;
    req_rd = '0;
    req_wr = '0;
    req_lba = '0;
    for (int i = 0; i < 4; i++) rem[i] = 0;
    repeat (3) tick();
    chk("rst_sd_rd", sd_rd, 0);
    chk("rst_sd_wr", sd_wr, 0);
    chk("rst_req_act", req_act, 0);
    chk("rst_done_err", {req_done, req_err}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_sd_lba", sd_lba, 0);
    chk("rst_buff_wr", req_buff_wr, 0);
    reset = 1'b0;

    run_round(4'b1111, 4'b0000, {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0A00},
              4'b0001, 2, 6, 2, 1'b1);
    run_round(4'b0100, 4'b0000, {32'h0, 32'h0000_0120, 64'h0}, 4'b0, 5, 514, 256, 1'b1);
    run_round(4'b0000, 4'b0010, {64'h0, 32'h0000_0B10, 32'h0}, 4'b0, 3, 1026, 512, 1'b1);
    run_round(4'b0001, 4'b0000, {96'h0, 32'h0000_0777}, 4'b0, 0, 0, 0, 1'b0);
    run_round(4'b1000, 4'b1000, {32'hFFFF_FFFF, 96'h0}, 4'b0, 2, 8, 3, 1'b1);

    // reset while requester 2 is mid-transfer
    tick();
    g = '{default: 0};
    g.is_grant = 1'b1; g.mode = 0; g.exp_cyc = cyc + 1; g.own = 2;
    g.rd = 4'b0100; g.lba = 32'hABCD_0002;
    exp_q.push_back(g);
    p.ack = 1'b1; p.dly = 3; p.len = 60; p.pulses = 29;
    plan_q.push_back(p);
    req_lba[95:64] = 32'hABCD_0002;
    req_rd = 4'b0100;
    repeat (10) tick();
    reset = 1'b1;
    req_rd = '0;
    tick();
    reset = 1'b0;
    chk("midrst_sd_rd_wr", {sd_rd, sd_wr}, 0);
    chk("midrst_req_act", req_act, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_owner", owner, 0);
    chk("midrst_sd_lba", sd_lba, 0);
    chk("midrst_ack_still_high", sd_ack, 1);
    m_last = 0;
    buff_snap = buff_total;
    g = '{default: 0};
    g.is_grant = 1'b1; g.mode = 2; g.own = 3; g.rd = 4'b1000; g.lba = 32'h0000_3333;
    f = '{default: 0};
    f.own = 3; f.done = 4'b1000; f.buff = 4;
    exp_q.push_back(g);
    exp_q.push_back(f);
    p.ack = 1'b1; p.dly = 2; p.len = 10; p.pulses = 4;
    plan_q.push_back(p);
    m_last = 3;
    rem[3] = 1;
    req_lba[127:96] = 32'h0000_3333;
    req_rd = 4'b1000;
    wait_round();
    chk("unowned_buff_pulses", buff_at_grant - buff_snap, 0);

    for (r = 0; r < 25; r++) begin
      mask = 4'($urandom_range(1, 15));
      rdm = '0;
      wrm = '0;
      for (int i = 0; i < 4; i++)
        if (mask[i]) begin
          case ($urandom_range(0, 2))
            0:       rdm[i] = 1'b1;
            1:       wrm[i] = 1'b1;
            default: begin rdm[i] = 1'b1; wrm[i] = 1'b1; end
          endcase
        end
      twice = ($urandom_range(0, 3) == 0) ? (mask & 4'($urandom_range(0, 15))) : 4'b0;
      run_round(rdm, wrm, {$urandom, $urandom, $urandom, $urandom}, twice, -1, 0, 0, 1'b1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
